// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- sequencing controller for the Beta instruction fetch stage.
//
// Converts the instruction-memory handshake, the decode-stage hazard and
// redirect requests and the external interrupt line into the fetch stage's
// stall / irq / ir_src_rf controls. It also runs a memory-timeout watchdog
// that latches a fault. No datapath registers live here.
//
// Parameters
//   MEM_TIMEOUT   consecutive un-acked request cycles that trip the watchdog
//                 (2..255)
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   imem_ack        instruction data for the current address is valid
//   imem_req        fetch request to instruction memory
//   hazard_stall    decode asks the fetch stage to hold
//   redirect        decode is changing flow this cycle
//   supv            supervisor bit of the instruction in RF (masks interrupts)
//   irq_line        level-sensitive interrupt request
//   irq_ack         one-cycle pulse when an interrupt is taken
//   stall, irq      fetch stage controls
//   ir_src_rf       fetch IR source select (DATA / NOP / EXCEPT)
//   fetch_fault     sticky watchdog fault, cleared only by rst
//   perf_stall_cnt  stall cycles outside BOOT/FAULT  (FETCH_CTRL_PERF_EN only)
//   perf_squash_cnt redirect-annulled slots          (FETCH_CTRL_PERF_EN only)
//   state_dbg       current FSM state encoding
//
// Optional feature: define FETCH_CTRL_PERF_EN to build the performance
// counters and their ports. Without it both are absent.
//
// Memory handshake: imem_req is held high for every cycle the controller
// wants an instruction; a cycle with imem_req=1 and imem_ack=1 delivers the
// instruction for the current address. Without an ack the request stays up
// and the same address is presented again the next cycle.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ack,
    output logic        imem_req,
    input  logic        hazard_stall,
    input  logic        redirect,
    input  logic        supv,
    input  logic        irq_line,
    output logic        irq_ack,
    output logic        stall,
    output logic        irq,
    output logic [1:0]  ir_src_rf,
    output logic        fetch_fault,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_squash_cnt,
`endif
    output logic [2:0]  state_dbg
);

    // IR source encodings shared with the fetch stage.
    localparam logic [1:0] IR_SRC_DATA   = 2'd0;
    localparam logic [1:0] IR_SRC_NOP    = 2'd1;
    localparam logic [1:0] IR_SRC_EXCEPT = 2'd2;

    localparam logic [7:0] WD_LIMIT = 8'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_BOOT     = 3'd0,
        S_RUN      = 3'd1,
        S_WAIT     = 3'd2,
        S_TAKE_IRQ = 3'd3,
        S_FAULT    = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] wd_q, wd_d;
    logic [7:0] wd_inc;
    // Interrupt arm flag: cleared by a take, set again once supv is seen high.
    // The instruction in RF can still be user-mode for a cycle or two after a
    // take, so this stops a second take before the handler reaches RF.
    logic       armed_q, armed_d;
    logic       take;
    logic       squash;

    assign wd_inc = wd_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        imem_req    = 1'b0;
        stall       = 1'b1;
        irq         = 1'b0;
        irq_ack     = 1'b0;
        ir_src_rf   = IR_SRC_NOP;
        fetch_fault = 1'b0;
        take        = 1'b0;
        squash      = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end

            S_RUN, S_WAIT: begin
                imem_req = 1'b1;
                stall    = ~imem_ack | hazard_stall;
                if (!imem_ack) begin
                    ir_src_rf = IR_SRC_NOP;
                end else if (redirect) begin
                    // Annul the wrong-path slot; only in the ack cycle, so a
                    // redirect held across a wait squashes exactly once.
                    ir_src_rf = IR_SRC_NOP;
                    squash    = 1'b1;
                end else begin
                    ir_src_rf = IR_SRC_DATA;
                end

                // Never take alongside a redirect so the saved XP is the
                // sequential PC.
                take = (state_q == S_RUN) && irq_line && !supv && imem_ack &&
                       !hazard_stall && !redirect && armed_q;

                wd_d = imem_ack ? 8'd0 : wd_inc;

                if (!imem_ack && (wd_inc >= WD_LIMIT)) begin
                    state_d = S_FAULT;
                end else if (take) begin
                    state_d = S_TAKE_IRQ;
                end else if (!imem_ack) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_RUN;
                end
            end

            S_TAKE_IRQ: begin
                stall     = 1'b0;
                irq       = 1'b1;
                irq_ack   = 1'b1;
                ir_src_rf = IR_SRC_EXCEPT;
                if (imem_ack) begin
                    wd_d = 8'd0;
                end
                state_d   = S_RUN;
            end

            S_FAULT: begin
                fetch_fault = 1'b1;
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_comb begin
        armed_d = armed_q;
        if (take) begin
            armed_d = 1'b0;
        end else if (supv) begin
            armed_d = 1'b1;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [31:0] perf_squash_cnt_q, perf_squash_cnt_d;

    always_comb begin
        perf_stall_cnt_d  = perf_stall_cnt_q;
        perf_squash_cnt_d = perf_squash_cnt_q;
        if (stall && (state_q != S_BOOT) && (state_q != S_FAULT)) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        end
        if (squash) begin
            perf_squash_cnt_d = perf_squash_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_q  <= 32'd0;
            perf_squash_cnt_q <= 32'd0;
        end else begin
            perf_stall_cnt_q  <= perf_stall_cnt_d;
            perf_squash_cnt_q <= perf_squash_cnt_d;
        end
    end

    assign perf_stall_cnt  = perf_stall_cnt_q;
    assign perf_squash_cnt = perf_squash_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
            wd_q    <= 8'd0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            armed_q <= armed_d;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl -- directed plus randomised-wait bench for fetch_ctrl.
// Expected output vectors {imem_req, stall, irq, irq_ack, ir_src_rf,
// fetch_fault} are queued as each cycle's stimulus is driven and compared on
// the following falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam logic [1:0] SRC_DATA = 2'd0;
    localparam logic [1:0] SRC_NOP  = 2'd1;
    localparam logic [1:0] SRC_EXC  = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ack;
    logic        imem_req;
    logic        hazard_stall;
    logic        redirect;
    logic        supv;
    logic        irq_line;
    logic        irq_ack;
    logic        stall;
    logic        irq;
    logic [1:0]  ir_src_rf;
    logic        fetch_fault;
    logic [2:0]  state_dbg;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_squash_cnt;
`endif

    fetch_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_ack        (imem_ack),
        .imem_req        (imem_req),
        .hazard_stall    (hazard_stall),
        .redirect        (redirect),
        .supv            (supv),
        .irq_line        (irq_line),
        .irq_ack         (irq_ack),
        .stall           (stall),
        .irq             (irq),
        .ir_src_rf       (ir_src_rf),
        .fetch_fault     (fetch_fault),
`ifdef FETCH_CTRL_PERF_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_squash_cnt (perf_squash_cnt),
`endif
        .state_dbg       (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    logic [6:0] exp_q[$];
    string      tag_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         exp_stall = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ov(input logic req, input logic st, input logic iq,
                                      input logic ia, input logic [1:0] src,
                                      input logic flt);
        return {req, st, iq, ia, src, flt};
    endfunction

    logic [6:0] boot_v, run_v, wait_v, take_v, fault_v, squash_v, hazard_v;

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic a, input logic h, input logic d,
                        input logic s, input logic i, input logic [6:0] exp,
                        input string tag);
        logic [6:0] e;
        string      t;
        @(posedge clk);
        #1;
        rst          = r;
        imem_ack     = a;
        hazard_stall = h;
        redirect     = d;
        supv         = s;
        irq_line     = i;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, {25'd0, imem_req, stall, irq, irq_ack, ir_src_rf, fetch_fault}, {25'd0, e});
    endtask

    task automatic cyc(input logic a, input logic h, input logic d, input logic s,
                       input logic i, input logic [6:0] exp, input string tag);
        step(1'b0, a, h, d, s, i, exp, tag);
    endtask

    task automatic perf(input int st, input int sq, input string tag);
`ifdef FETCH_CTRL_PERF_EN
        chk({tag, "_stall_cnt"}, perf_stall_cnt, st);
        chk({tag, "_squash_cnt"}, perf_squash_cnt, sq);
`else
        if (tag.len() < 0) $display("%0d %0d", st, sq);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        imem_ack     = 1'b1;
        hazard_stall = 1'b0;
        redirect     = 1'b0;
        supv         = 1'b0;
        irq_line     = 1'b0;

        boot_v   = ov(1'b0, 1'b1, 1'b0, 1'b0, SRC_NOP,  1'b0);
        run_v    = ov(1'b1, 1'b0, 1'b0, 1'b0, SRC_DATA, 1'b0);
        wait_v   = ov(1'b1, 1'b1, 1'b0, 1'b0, SRC_NOP,  1'b0);
        take_v   = ov(1'b0, 1'b0, 1'b1, 1'b1, SRC_EXC,  1'b0);
        fault_v  = ov(1'b0, 1'b1, 1'b0, 1'b0, SRC_NOP,  1'b1);
        squash_v = ov(1'b1, 1'b0, 1'b0, 1'b0, SRC_NOP,  1'b0);
        hazard_v = ov(1'b1, 1'b1, 1'b0, 1'b0, SRC_DATA, 1'b0);

        // Reset release with zero-wait memory.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, boot_v, "rst_hold");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, boot_v, "boot_cycle");
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, run_v, "zero_wait_fetch");
        perf(0, 0, "after_boot");

        // Three-cycle memory wait (below the watchdog limit).
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, wait_v, "mem_wait");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, run_v, "wait_ack");
        perf(3, 0, "after_wait");

        // Operand hazard: stall with data still selected.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, hazard_v, "hazard");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, run_v, "after_hazard");
        perf(4, 0, "after_hazard");

        // Redirect held across a two-cycle wait.
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, wait_v, "redir_wait");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, squash_v, "redir_ack");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, run_v, "after_redir");
        exp_stall = 6;
        perf(exp_stall, 1, "after_redir");

        // Random wait lengths.
        for (int k = 0; k < 4; k++) begin
            int n;
            n = $urandom_range(1, 3);
            repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, wait_v, "rand_wait");
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, run_v, "rand_ack");
            exp_stall += n;
            perf(exp_stall, 1, "rand_wait");
        end

        // Interrupt coincident with redirect, then taken; no immediate retake.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, squash_v, "irq_with_redirect");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, run_v, "irq_take_cond");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, take_v, "irq_take");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, run_v, "irq_no_retake");
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, run_v, "irq_supv_masked");
        perf(exp_stall, 2, "after_irq");

        // Supervisor mode left: interrupt taken again, reset during TAKE_IRQ.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, run_v, "irq_rearm_cond");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, take_v, "rst_in_take");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, boot_v, "boot_after_take");
        perf(0, 0, "boot_after_take");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, run_v, "run_after_take_rst");

        // Watchdog: no ack for MEM_TIMEOUT cycles.
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, wait_v, "wd_wait");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fault_v, "wd_fault");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, fault_v, "fault_sticky_ack");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, fault_v, "fault_sticky_irq");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, fault_v, "rst_in_fault");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, boot_v, "boot_after_fault");
        perf(0, 0, "boot_after_fault");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, run_v, "run_after_fault");

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
